uart_rx: RTL and testbench

- Serial receiver for the UART link. It is the counterpart of the uart_tx transmitter.
- Frame format: 8N1, LSB first, line idle high. Each frame is 1 start bit (0), 8 data bits, then 1 stop bit (1).
- Baud rate is selected with the same 2-bit freq_control encoding the transmitter uses.
- The block presents each received byte with a valid/ack handshake to the host-side logic.

---
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling at a baud rate chosen by
// freq_control, and a valid/ack handoff of each received byte with frame-error and overrun flags.
module uart_rx (
    input  logic       uart_clock,
    input  logic       uart_reset,
    input  logic       uart_rx_in,
    input  logic [1:0] freq_control,
    input  logic       uart_rx_ack,
    output logic [7:0] uart_d_out,
    output logic       uart_rx_valid,
    output logic       uart_rx_frame_err,
    output logic       uart_rx_overrun
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        START_CHECK  = 2'd1,
        RECEIVE_DATA = 2'd2,
        STOP_CHECK   = 2'd3
    } state_t;

    function automatic logic [15:0] pulse_duration(input logic [1:0] sel);
        logic [15:0] pd;
        case (sel)
            2'b00:   pd = 16'd5208;
            2'b01:   pd = 16'd434;
            2'b10:   pd = 16'd50;
            default: pd = 16'd12;
        endcase
        return pd;
    endfunction

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        rx_s_q, rx_s_d;
    logic        rx_d_q, rx_d_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] pd_q, pd_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    logic        start_edge;
    logic [15:0] half_pd;

    assign start_edge = rx_d_q & ~rx_s_q;
    assign half_pd    = {1'b0, pd_q[15:1]};

    always_comb begin
        sync1_d     = uart_rx_in;
        rx_s_d      = sync1_q;
        rx_d_d      = rx_s_q;
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pd_d        = pd_q;
        d_out_d     = d_out_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        if (valid_q && uart_rx_ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    clk_cnt_d = 16'd0;
                    pd_d      = pulse_duration(freq_control);
                    state_d   = START_CHECK;
                end
            end
            START_CHECK: begin
                if (clk_cnt_q == half_pd) begin
                    // A line that is high again at mid start bit was a glitch.
                    if (!rx_s_q) begin
                        clk_cnt_d = 16'd0;
                        bit_cnt_d = 3'd0;
                        state_d   = RECEIVE_DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            RECEIVE_DATA: begin
                if (clk_cnt_q == pd_q) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    clk_cnt_d = 16'd0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP_CHECK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            STOP_CHECK: begin
                if (clk_cnt_q == pd_q) begin
                    // Leave mid stop bit so a back-to-back start edge is not missed.
                    state_d   = IDLE;
                    clk_cnt_d = 16'd0;
                    if (rx_s_q) begin
                        if (!valid_q || uart_rx_ack) begin
                            d_out_d = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            state_q     <= IDLE;
            clk_cnt_q   <= 16'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            pd_q        <= 16'd0;
            d_out_q     <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            rx_d_q      <= rx_d_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pd_q        <= pd_d;
            d_out_q     <= d_out_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign uart_d_out        = d_out_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_frame_err = frame_err_q;
    assign uart_rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames on the serial line and checks every cycle against a
// frame-level model (byte outcome scheduled at the stop-sample edge), plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic [1:0] freq = 2'b11;
    logic       ack_dir = 1'b0;
    logic       ack_rnd = 1'b0;
    logic       rand_en = 1'b0;
    logic       ack;
    logic [7:0] d_out;
    logic       valid;
    logic       ferr;
    logic       ovr;

    assign ack = ack_dir | (rand_en & ack_rnd);

    uart_rx dut (
        .uart_clock        (clk),
        .uart_reset        (rst_n),
        .uart_rx_in        (rx_line),
        .freq_control      (freq),
        .uart_rx_ack       (ack),
        .uart_d_out        (d_out),
        .uart_rx_valid     (valid),
        .uart_rx_frame_err (ferr),
        .uart_rx_overrun   (ovr)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec_cyc = 0;
    int n_err_cyc = 0;
    int n_vec_lit = 0;
    int n_err_lit = 0;

    typedef struct {
        int unsigned due;
        logic [7:0]  data;
        logic        good;
    } ev_t;
    ev_t ev_q[$];

    logic [7:0] m_d = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;

    function automatic int unsigned pd_of(input logic [1:0] f);
        case (f)
            2'b00:   return 5208;
            2'b01:   return 434;
            2'b10:   return 50;
            default: return 12;
        endcase
    endfunction

    // Frame driving starts just after edge n; the first edge seeing the low line is n+1, and
    // the byte outcome lands 2 + H + 9*(PD+1) + 1 edges later.
    function automatic int unsigned stop_edge(input int unsigned n, input logic [1:0] f);
        return (n + 1) + 2 + pd_of(f) / 2 + 9 * (pd_of(f) + 1) + 1;
    endfunction

    // Frame-level model: applies the handshake rules at each clock edge.
    always @(posedge clk or negedge rst_n) begin
        int unsigned e;
        logic [7:0]  nd;
        logic        nv, no, nf;
        if (!rst_n) begin
            m_d     <= 8'h00;
            m_valid <= 1'b0;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
            ev_q.delete();
        end else begin
            e  = cyc + 1;
            nd = m_d;
            nv = m_valid;
            no = m_ovr;
            nf = 1'b0;
            if (m_valid && ack) begin
                nv = 1'b0;
                no = 1'b0;
            end
            if (ev_q.size() > 0 && ev_q[0].due == e) begin
                if (ev_q[0].good) begin
                    if (!m_valid || ack) begin
                        nd = ev_q[0].data;
                        nv = 1'b1;
                    end else begin
                        no = 1'b1;
                    end
                end else begin
                    nf = 1'b1;
                end
                void'(ev_q.pop_front());
            end
            m_d     <= nd;
            m_valid <= nv;
            m_ovr   <= no;
            m_ferr  <= nf;
        end
    end

    always @(negedge clk) begin
        n_vec_cyc++;
        if (d_out !== m_d || valid !== m_valid || ferr !== m_ferr || ovr !== m_ovr) begin
            n_err_cyc++;
            $display("FAIL cycle_check cyc=%0d actual d=%h v=%b ferr=%b ovr=%b required d=%h v=%b ferr=%b ovr=%b",
                     cyc, d_out, valid, ferr, ovr, m_d, m_valid, m_ferr, m_ovr);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        ack_rnd = ($urandom_range(0, 9) == 0);
    end

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec_lit++;
        if (act !== exp) begin
            n_err_lit++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic [1:0] f);
        int per;
        ev_t ev;
        per     = int'(pd_of(f)) + 1;
        ev.due  = stop_edge(cyc, f);
        ev.data = b;
        ev.good = stop;
        ev_q.push_back(ev);
        rx_line = 1'b0;
        step(per);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            step(per);
        end
        rx_line = stop;
        step(per);
        rx_line = 1'b1;
        if (!stop) step(per);
    endtask

    task automatic pulse_ack();
        ack_dir = 1'b1;
        step(1);
        ack_dir = 1'b0;
    endtask

    initial begin
        int unsigned n;
        int unsigned se;
        logic [7:0]  last;
        logic [7:0]  pat [4];
        logic [1:0]  f;
        logic [7:0]  b;
        logic        stop;

        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h3C; pat[3] = 8'h81;

        step(3);
        check("reset_d_out", d_out, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_frame_err", ferr, 1'b0);
        check("reset_overrun", ovr, 1'b0);
        rst_n = 1'b1;
        step(5);

        // Basic receive of 0xA5 at 13 cycles/bit, valid exactly 126 edges after the start edge.
        freq = 2'b11;
        n = cyc;
        fork
            send_frame(8'hA5, 1'b1, 2'b11);
            begin
                wait_cyc(n + 1 + 125);
                check("basic_valid_early", valid, 1'b0);
                wait_cyc(n + 1 + 126);
                check("basic_valid", valid, 1'b1);
                check("basic_d_out", d_out, 8'hA5);
                check("basic_frame_err", ferr, 1'b0);
            end
        join
        pulse_ack();
        check("basic_ack_clears", valid, 1'b0);

        for (int fi = 3; fi >= 2; fi--) begin
            for (int i = 0; i < 4; i++) begin
                freq = 2'(fi);
                send_frame(pat[i], 1'b1, 2'(fi));
                check("loop_d_out", d_out, pat[i]);
                check("loop_valid", valid, 1'b1);
                pulse_ack();
            end
        end
        freq = 2'b01;
        send_frame(8'hFF, 1'b1, 2'b01);
        check("loop01_d_out", d_out, 8'hFF);
        pulse_ack();
        freq = 2'b00;
        send_frame(8'h3C, 1'b1, 2'b00);
        check("loop00_d_out", d_out, 8'h3C);
        check("loop00_valid", valid, 1'b1);
        pulse_ack();
        last = 8'h3C;

        // Short low glitch then a frame with a bad stop bit.
        freq = 2'b11;
        rx_line = 1'b0;
        step(4);
        rx_line = 1'b1;
        step(30);
        check("glitch_valid", valid, 1'b0);
        n = cyc;
        se = stop_edge(n, 2'b11);
        fork
            send_frame(8'h5A, 1'b0, 2'b11);
            begin
                wait_cyc(se);
                check("ferr_pulse", ferr, 1'b1);
                check("ferr_valid", valid, 1'b0);
                check("ferr_d_out", d_out, last);
                step(1);
                check("ferr_one_cycle", ferr, 1'b0);
            end
        join

        // Overrun, then a good frame with ack on its stop-sample edge.
        send_frame(8'h11, 1'b1, 2'b11);
        send_frame(8'h22, 1'b1, 2'b11);
        check("ovr_d_out", d_out, 8'h11);
        check("ovr_set", ovr, 1'b1);
        check("ovr_valid", valid, 1'b1);
        pulse_ack();
        check("ovr_ack_valid", valid, 1'b0);
        check("ovr_ack_clear", ovr, 1'b0);
        send_frame(8'h11, 1'b1, 2'b11);
        send_frame(8'h33, 1'b1, 2'b11);
        check("ovr2_set", ovr, 1'b1);
        n = cyc;
        se = stop_edge(n, 2'b11);
        fork
            send_frame(8'h22, 1'b1, 2'b11);
            begin
                wait_cyc(se - 1);
                ack_dir = 1'b1;
                wait_cyc(se);
                ack_dir = 1'b0;
            end
        join
        check("simack_d_out", d_out, 8'h22);
        check("simack_valid", valid, 1'b1);
        check("simack_overrun", ovr, 1'b0);
        pulse_ack();

        // Baud select changed mid-frame applies from the next frame.
        freq = 2'b11;
        fork
            send_frame(8'h96, 1'b1, 2'b11);
            begin
                step(40);
                freq = 2'b01;
            end
        join
        check("fswitch_first", d_out, 8'h96);
        pulse_ack();
        send_frame(8'h4B, 1'b1, 2'b01);
        check("fswitch_second", d_out, 8'h4B);
        pulse_ack();

        // Reset during data bit 4, held until the frame is over.
        freq = 2'b11;
        n = cyc;
        fork
            send_frame(8'h77, 1'b1, 2'b11);
            begin
                wait_cyc(n + 5 * 13 + 4);
                rst_n = 1'b0;
                #1;
                check("midrst_d_out", d_out, 8'h00);
                check("midrst_valid", valid, 1'b0);
                check("midrst_frame_err", ferr, 1'b0);
                check("midrst_overrun", ovr, 1'b0);
            end
        join
        step(2);
        rst_n = 1'b1;
        step(3);
        send_frame(8'hC3, 1'b1, 2'b11);
        check("postrst_d_out", d_out, 8'hC3);
        check("postrst_valid", valid, 1'b1);
        pulse_ack();

        // Randomized frames, glitches, stop errors, mid-frame baud changes and random acks.
        rand_en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            f    = 2'($urandom_range(2, 3));
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            freq = f;
            if ($urandom_range(0, 4) == 0) begin
                rx_line = 1'b0;
                step($urandom_range(1, pd_of(f) / 2));
                rx_line = 1'b1;
                step(int'(pd_of(f)) + 10);
            end
            fork
                send_frame(b, stop, f);
                begin
                    step($urandom_range(5, 9 * (pd_of(f) + 1)));
                    freq = 2'($urandom_range(0, 3));
                end
            join
            step($urandom_range(0, 15));
        end
        rand_en = 1'b0;
        step(20);
        check("events_drained", ev_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec_cyc + n_vec_lit, n_err_cyc + n_err_lit);
        $finish;
    end

endmodule
